zap_mac_sequencer: RTL and testbench
====================================

# zap_mac_sequencer

Multi-cycle multiply-accumulate sequencer for the shift stage. It computes rd = (rm × rs + rn) mod 2^32 using a single 16×16 partial-product multiplier over three accumulate cycles. While it works, it holds the shift stage via a combinational busy/stall output. On the stage's MLA slot it replaces the single-cycle MAC unit, and it evaluates the instruction's condition code against next-CPSR flags so failed-condition multiplies cost no stall.

## Interface
- Parameters: none.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_clear  in  1  pipeline flush (writeback or ALU clear, ORed by parent); synchronous.
- i_hold  in  1  downstream data stall; freezes the sequencer in DONE.
- i_start  in  1  MLA present in stage; held high by parent while o_busy is high.
- i_cc  in  4  condition code of the instruction (EQ=0 … AL=14, NV=15).
- i_cpsr_nxt  in  32  next CPSR; flags N=[31], Z=[30], C=[29], V=[28].
- i_rm  in  32  multiplicand.
- i_rs  in  32  multiplier.
- i_rn  in  32  accumulate addend (0 for MUL).
- o_rd  out  32  accumulator register; valid in DONE.
- o_busy  out  1  combinational stall request to the shift stage.

## Operation
- States: IDLE, MUL1, MUL2, DONE. Registers: state, acc[31:0]. o_rd = acc continuously.
- Split operands: aL=rm[15:0], aH=rm[31:16], bL=rs[15:0], bH=rs[31:16]. Each partial product is 16×16 → 32 bits unsigned. The shifted product keeps bits [31:0] only. All sums are mod 2^32. aH×bH is never computed because it contributes nothing to the low word.
- pass = ARM condition evaluation of i_cc on i_cpsr_nxt flags. The 14 standard conditions are evaluated as defined; AL=1, NV=0.
- IDLE:
  - i_start & pass & !i_clear: acc ← rn + aL×bL, go to MUL1.
  - Otherwise stay in IDLE; acc holds.
- MUL1: acc ← acc + ((aH×bL)<<16), go to MUL2.
- MUL2: acc ← acc + ((aL×bH)<<16), go to DONE.
- DONE:
  - i_hold=1: stay in DONE; acc holds.
  - i_hold=0: go to IDLE; the parent registers o_rd on this edge.
- o_busy = !i_reset & !i_clear & i_start & pass & (state ≠ DONE).
- Priority: i_reset > i_clear > normal operation.
- i_clear in any state: state ← IDLE next edge; acc holds its value; o_busy is 0 in the clear cycle.
- i_start dropping in MUL1 or MUL2 (protocol violation or squash): state ← IDLE next edge; acc holds; o_busy=0.
- Condition fails (pass=0) with i_start=1 in IDLE: no state change, o_busy=0, acc unchanged. The parent discards o_rd because the instruction is condition-failed downstream.
- Operands must be stable while o_busy=1. The parent guarantees this by stalling. The sequencer does not latch rm, rs, or rn.

## Timing
- Reset values: state=IDLE, acc=0, o_rd=0, o_busy=0.
- Latency from i_start (passing) seen in IDLE at cycle 0:
  - o_busy=1 in cycles 0, 1, 2.
  - Cycle 3: state=DONE, o_busy=0, o_rd valid.
  - Total cost: 3 stall cycles per MLA.
- Back-to-back MLAs: the second i_start is first seen in cycle 4 (IDLE), giving the same 3-cycle stall again. No bubble is added beyond the DONE cycle.
- Failed-condition MLA: zero stall; the stage advances in the same cycle.
- i_hold held in DONE for k cycles: o_rd stable and o_busy=0 for those k cycles. Return to IDLE on the first edge with i_hold=0.
- i_reset mid-operation: state=IDLE and acc=0 on the next edge; o_busy=0 in the reset cycle itself.

## Test plan
- rm=3, rs=5, rn=7, cc=AL → o_busy=1 for exactly 3 cycles; DONE in cycle 3 with o_rd=22; IDLE in cycle 4.
- rm=0xFFFFFFFF, rs=0xFFFFFFFF, rn=0 → o_rd=0x00000001. Then rm=0x00010000, rs=0x00010000, rn=5 → o_rd=0x00000005 (product truncated).
- cc=EQ with i_cpsr_nxt Z=0, i_start=1 → o_busy never asserts, state stays IDLE, acc unchanged. Repeat with Z=1 → normal 3-cycle run.
- i_clear asserted in MUL2 → o_busy=0 that cycle, IDLE next cycle. Then rm=2, rs=3, rn=1 → o_rd=7 after a fresh 3-cycle run.
- i_hold=1 for 2 cycles on reaching DONE (rm=0x1234, rs=0x10000, rn=0) → o_rd=0x12340000 stable for 3 cycles total, o_busy=0; IDLE on the edge after i_hold drops.
- i_reset pulsed in MUL1 → next cycle state=IDLE, o_rd=0, o_busy=0. A subsequent MLA rm=4, rs=4, rn=4 → o_rd=20.

Source files
------------

// File: rtl/zap_mac_sequencer.sv
// rtl/zap_mac_sequencer.sv - multi-cycle 32-bit multiply-accumulate sequencer
// Computes rm*rs+rn mod 2^32 with one 16x16 multiplier over three accumulate cycles.

module zap_mac_sequencer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_hold,
  input  logic        i_start,
  input  logic [3:0]  i_cc,
  input  logic [31:0] i_cpsr_nxt,
  input  logic [31:0] i_rm,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rn,
  output logic [31:0] o_rd,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic        acc_en;
  logic        pass;
  logic        go;

  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        unused_cpsr;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [31:0] pp;

  assign flag_n      = i_cpsr_nxt[31];
  assign flag_z      = i_cpsr_nxt[30];
  assign flag_c      = i_cpsr_nxt[29];
  assign flag_v      = i_cpsr_nxt[28];
  assign unused_cpsr = ^i_cpsr_nxt[27:0];

  always_comb begin
    pass = 1'b0;
    case (i_cc)
      4'd0:    pass = flag_z;
      4'd1:    pass = !flag_z;
      4'd2:    pass = flag_c;
      4'd3:    pass = !flag_c;
      4'd4:    pass = flag_n;
      4'd5:    pass = !flag_n;
      4'd6:    pass = flag_v;
      4'd7:    pass = !flag_v;
      4'd8:    pass = flag_c && !flag_z;
      4'd9:    pass = !flag_c || flag_z;
      4'd10:   pass = (flag_n == flag_v);
      4'd11:   pass = (flag_n != flag_v);
      4'd12:   pass = !flag_z && (flag_n == flag_v);
      4'd13:   pass = flag_z || (flag_n != flag_v);
      4'd14:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign go = i_start && pass;

  // The high-by-high partial product only affects bits above 31, so it is never formed.
  always_comb begin
    op_a = i_rm[15:0];
    op_b = i_rs[15:0];
    case (state)
      MUL1:    op_a = i_rm[31:16];
      MUL2:    op_b = i_rs[31:16];
      default: ;
    endcase
  end

  assign pp = {16'b0, op_a} * {16'b0, op_b};

  always_comb begin
    if (state == IDLE) begin
      acc_nxt = i_rn + pp;
    end else begin
      acc_nxt = acc + {pp[15:0], 16'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      acc   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (acc_en) begin
        acc <= acc_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (go) state_nxt = MUL1;
        MUL1:    state_nxt = go ? MUL2 : IDLE;
        MUL2:    state_nxt = go ? DONE : IDLE;
        DONE:    if (!i_hold) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = !i_reset && !i_clear && go && (state != DONE);
    acc_en = !i_clear && go && (state != DONE);
  end

  assign o_rd = acc;

endmodule

// File: tb/tb_zap_mac_sequencer.sv
// tb/tb_zap_mac_sequencer.sv - directed self-checking bench for zap_mac_sequencer

module tb_zap_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        hold;
  logic        start;
  logic [3:0]  cc;
  logic [31:0] cpsr;
  logic [31:0] rm;
  logic [31:0] rs;
  logic [31:0] rn;
  logic [31:0] rd;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // {cc, NZCV, expected pass}
  logic [8:0] cond_tbl [0:20] = '{
    {4'd0,  4'b0000, 1'b0}, {4'd0,  4'b0100, 1'b1}, {4'd1,  4'b0100, 1'b0},
    {4'd2,  4'b0010, 1'b1}, {4'd3,  4'b0010, 1'b0}, {4'd4,  4'b1000, 1'b1},
    {4'd5,  4'b1000, 1'b0}, {4'd6,  4'b0000, 1'b0}, {4'd7,  4'b0000, 1'b1},
    {4'd8,  4'b0010, 1'b1}, {4'd8,  4'b0110, 1'b0}, {4'd9,  4'b0000, 1'b1},
    {4'd10, 4'b1000, 1'b0}, {4'd10, 4'b1001, 1'b1}, {4'd11, 4'b0001, 1'b1},
    {4'd12, 4'b1001, 1'b1}, {4'd12, 4'b0100, 1'b0}, {4'd13, 4'b1000, 1'b1},
    {4'd13, 4'b0000, 1'b0}, {4'd14, 4'b0000, 1'b1}, {4'd15, 4'b1111, 1'b0}
  };

  always #5 clk = ~clk;

  zap_mac_sequencer dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_clear    (clr),
    .i_hold     (hold),
    .i_start    (start),
    .i_cc       (cc),
    .i_cpsr_nxt (cpsr),
    .i_rm       (rm),
    .i_rs       (rs),
    .i_rn       (rn),
    .o_rd       (rd),
    .o_busy     (busy)
  );

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [3:0] code, input logic [3:0] nzcv, input logic st);
    rm    = a;
    rs    = b;
    rn    = c;
    cc    = code;
    cpsr  = {nzcv, 28'h0};
    start = st;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_op(32'd3, 32'd5, 32'd7, 4'd14, 4'b0000, 1'b1);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_in_reset: got %b want 0", busy);
    end
    next_cycle();
    rst   = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_rd: got %h want 00000000", rd);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_basic_back_to_back();
    set_op(32'd3, 32'd5, 32'd7, 4'd14, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_busy c%0d: got %b want 1", i, busy);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || rd !== 32'd22) begin
      failures++;
      $display("FAIL basic_done: got busy=%b rd=%h want busy=0 rd=00000016", busy, rd);
    end
    // second MLA presented immediately; must be accepted in cycle 4
    next_cycle();
    set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'd14, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_busy c%0d: got %b want 1", i, busy);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || rd !== 32'h0000_0001) begin
      failures++;
      $display("FAIL b2b_ones_done: got busy=%b rd=%h want busy=0 rd=00000001", busy, rd);
    end
    next_cycle();
    set_op(32'h0001_0000, 32'h0001_0000, 32'd5, 4'd14, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL trunc_busy c%0d: got %b want 1", i, busy);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || rd !== 32'h0000_0005) begin
      failures++;
      $display("FAIL trunc_done: got busy=%b rd=%h want busy=0 rd=00000005", busy, rd);
    end
    next_cycle();
    start = 1'b0;
    next_cycle();
  endtask

  task automatic test_condition();
    logic [31:0] exp_rd;
    logic [8:0]  ent;
    exp_rd = 32'd5;
    for (int i = 0; i < 21; i++) begin
      ent = cond_tbl[i];
      set_op(32'd3, 32'd5, 32'd7, ent[8:5], ent[4:1], 1'b1);
      #1;
      checks++;
      if (busy !== ent[0]) begin
        failures++;
        $display("FAIL cond_busy cc=%0d nzcv=%b: got %b want %b", ent[8:5], ent[4:1], busy, ent[0]);
      end
      if (ent[0]) exp_rd = 32'd22;
      next_cycle();
      start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rd !== exp_rd) begin
        failures++;
        $display("FAIL cond_after cc=%0d: got busy=%b rd=%h want busy=0 rd=%h", ent[8:5], busy, rd, exp_rd);
      end
      next_cycle();
    end
    set_op(32'd6, 32'd7, 32'd0, 4'd0, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL cond_eq_busy c%0d: got %b want 1", i, busy);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || rd !== 32'd42) begin
      failures++;
      $display("FAIL cond_eq_done: got busy=%b rd=%h want busy=0 rd=0000002a", busy, rd);
    end
    next_cycle();
    start = 1'b0;
    next_cycle();
  endtask

  task automatic test_clear();
    set_op(32'd1, 32'h0001_0001, 32'd0, 4'd14, 4'b0000, 1'b1);
    #1;
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_mul1_busy: got %b want 1", busy);
    end
    next_cycle();
    clr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rd !== 32'd1) begin
      failures++;
      $display("FAIL clear_cycle: got busy=%b rd=%h want busy=0 rd=00000001", busy, rd);
    end
    next_cycle();
    clr = 1'b0;
    set_op(32'd2, 32'd3, 32'd1, 4'd14, 4'b0000, 1'b1);
    #1;
    checks++;
    if (busy !== 1'b1 || rd !== 32'd1) begin
      failures++;
      $display("FAIL clear_after: got busy=%b rd=%h want busy=1 rd=00000001", busy, rd);
    end
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL clear_rerun_busy c%0d: got %b want 1", i, busy);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || rd !== 32'd7) begin
      failures++;
      $display("FAIL clear_rerun_done: got busy=%b rd=%h want busy=0 rd=00000007", busy, rd);
    end
    next_cycle();
    start = 1'b0;
    next_cycle();
  endtask

  task automatic test_hold();
    set_op(32'h0000_1234, 32'h0001_0000, 32'd0, 4'd14, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_busy c%0d: got %b want 1", i, busy);
      end
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      hold = (i < 2);
      #1;
      checks++;
      if (busy !== 1'b0 || rd !== 32'h1234_0000) begin
        failures++;
        $display("FAIL hold_done k%0d: got busy=%b rd=%h want busy=0 rd=12340000", i, busy, rd);
      end
    end
    next_cycle();
    hold = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_release_idle: got busy=%b want 1", busy);
    end
    next_cycle();
    start = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    set_op(32'd3, 32'd5, 32'd7, 4'd14, 4'b0000, 1'b1);
    #1;
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_busy: got %b want 0", busy);
    end
    next_cycle();
    rst = 1'b0;
    set_op(32'd4, 32'd4, 32'd4, 4'd14, 4'b0000, 1'b1);
    #1;
    checks++;
    if (busy !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_after: got busy=%b rd=%h want busy=1 rd=00000000", busy, rd);
    end
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_busy c%0d: got %b want 1", i, busy);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || rd !== 32'd20) begin
      failures++;
      $display("FAIL rstmid_done: got busy=%b rd=%h want busy=0 rd=00000014", busy, rd);
    end
    next_cycle();
    start = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst  = 1'b1;
    clr  = 1'b0;
    hold = 1'b0;
    set_op(32'd0, 32'd0, 32'd0, 4'd14, 4'b0000, 1'b0);
    repeat (2) next_cycle();
    test_reset();
    test_basic_back_to_back();
    test_condition();
    test_clear();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
